// File: rtl/instr_encoder_pkg.sv
// Shared encoder/decoder definitions: format codes, opcode constants and
// field widths, plus the FIFO entry layout and occupancy states.
package instr_encoder_pkg;

   localparam int XLEN     = 32;
   localparam int OPCODE_W = 7;
   localparam int REG_W    = 5;
   localparam int FUNC_W   = 10;   // {funct7, funct3}
   localparam int FMT_W    = 3;

   // Immediate format codes; values outside this set encode as NO_IMM.
   typedef enum logic [FMT_W-1:0] {
      FORMAT_U      = 3'd0,
      FORMAT_I      = 3'd1,
      FORMAT_S      = 3'd2,
      FORMAT_B      = 3'd3,
      FORMAT_J      = 3'd4,
      FORMAT_NO_IMM = 3'd5
   } fmt_e;

   localparam logic [OPCODE_W-1:0] OP_LUI    = 7'h37;
   localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'h17;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'h6F;
   localparam logic [OPCODE_W-1:0] OP_JALR   = 7'h67;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'h63;
   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'h03;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'h23;
   localparam logic [OPCODE_W-1:0] OP_IMM    = 7'h13;
   localparam logic [OPCODE_W-1:0] OP_REG    = 7'h33;

   // One buffered output word: encoded instruction plus its memory address.
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] addr;
   } fifo_entry_t;

   typedef enum logic [1:0] {
      FIFO_EMPTY,
      FIFO_PARTIAL,
      FIFO_FULL
   } fifo_state_e;

endpackage

// File: rtl/instr_enc_fifo.sv
// Output buffer for the instruction encoder: FIFO_DEPTH entries of
// {instr, addr}. Occupancy is tracked by an EMPTY/PARTIAL/FULL state machine
// alongside an entry count. Head data reads as zero while empty.
module instr_enc_fifo
   import instr_encoder_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic [63:0] push_data,
   input  logic        pop,
   output logic        full,
   output logic        valid,
   output logic [63:0] head_data
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] LAST_FREE = CNT_W'(FIFO_DEPTH - 1);

   fifo_state_e      state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [63:0]      mem [FIFO_DEPTH];
   logic             do_push, do_pop;

   assign do_push = push && (state_q != FIFO_FULL);
   assign do_pop  = pop && (state_q != FIFO_EMPTY);

   // Next occupancy state and count; push+pop together leaves both unchanged.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
      state_d = state_q;
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
      case (state_q)
         FIFO_EMPTY: begin
            if (do_push) state_d = FIFO_PARTIAL;
         end
         FIFO_PARTIAL: begin
            if (do_push && !do_pop && count_q == LAST_FREE) begin
               state_d = FIFO_FULL;
            end else if (do_pop && !do_push && count_q == CNT_W'(1)) begin
               state_d = FIFO_EMPTY;
            end
         end
         FIFO_FULL: begin
            if (do_pop) state_d = FIFO_PARTIAL;
         end
         default: state_d = FIFO_EMPTY;
      endcase
   end

   // Occupancy state, count and pointer registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q  <= FIFO_EMPTY;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; the EMPTY state masks stale contents on the read side.
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

   assign full      = (state_q == FIFO_FULL);
   assign valid     = (state_q != FIFO_EMPTY);
   assign head_data = valid ? mem[rd_ptr_q] : '0;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs opcode/register/func/immediate fields into a
// 32-bit instruction word, holds it in one stage register, then queues it
// with its instruction-memory address in an output FIFO.
// Optional feature macro: INSTR_ENC_IMM_CHECK_EN -- when defined, requests
// whose immediate does not fit the format set the sticky err flag and are
// dropped; when undefined, immediates are truncated and err is tied low.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [9:0]  in_func,
   input  logic [31:0] in_imm,
   input  logic        addr_ld,
   input  logic [31:0] addr_ld_val,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        err
);

   // Field packing for each immediate format; unknown codes pack as NO_IMM.
   function automatic logic [31:0] pack_instr(
      input logic [2:0]  fmt,
      input logic [6:0]  op,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [9:0]  func,
      input logic [31:0] imm
   );
      logic [6:0] f7;
      logic [2:0] f3;
      f7 = func[9:3];
      f3 = func[2:0];
      case (fmt)
         FORMAT_U: pack_instr = {imm[31:12], rd, op};
         FORMAT_I: pack_instr = {imm[11:0], rs1, f3, rd, op};
         FORMAT_S: pack_instr = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         FORMAT_B: pack_instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         FORMAT_J: pack_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         default:  pack_instr = {f7, rs2, rs1, f3, rd, op};
      endcase
   endfunction

`ifdef INSTR_ENC_IMM_CHECK_EN
   // True when the immediate cannot be represented exactly in its format.
   function automatic logic imm_out_of_range(input logic [2:0] fmt, input logic [31:0] imm);
      case (fmt)
         FORMAT_I, FORMAT_S: imm_out_of_range = (imm[31:11] != {21{imm[11]}});
         FORMAT_B:           imm_out_of_range = (imm[31:12] != {20{imm[12]}}) || imm[0];
         FORMAT_J:           imm_out_of_range = (imm[31:20] != {12{imm[20]}}) || imm[0];
         FORMAT_U:           imm_out_of_range = (imm[11:0] != 12'h000);
         default:            imm_out_of_range = 1'b0;
      endcase
   endfunction
`endif

   logic        stage_valid_q;
   logic [31:0] stage_instr_q;
   logic [31:0] wr_addr_q;
   logic        fifo_full;
   logic        accept, imm_bad, load_stage, push;
   logic [31:0] ld_addr, push_addr;
   fifo_entry_t push_entry, head_entry;

   // Ready depends only on registered state, never on out_ready.
   assign in_ready   = !(stage_valid_q && fifo_full);
   assign accept     = in_valid && in_ready;
   assign load_stage = accept && !imm_bad;
   assign push       = stage_valid_q && !fifo_full;

   // Word-aligned load value; a load on the push edge addresses that push.
   assign ld_addr   = addr_ld_val & 32'hFFFF_FFFC;
   assign push_addr = addr_ld ? ld_addr : wr_addr_q;

`ifdef INSTR_ENC_IMM_CHECK_EN
   logic err_q;

   assign imm_bad = imm_out_of_range(in_fmt, in_imm);
   assign err     = err_q;

   // Sticky range error, set when an out-of-range request is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept && imm_bad) begin
         err_q <= 1'b1;
      end
   end
`else
   assign imm_bad = 1'b0;
   assign err     = 1'b0;
`endif

   // Stage register: loads the packed word, empties when it moves to the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_valid_q <= 1'b0;
         stage_instr_q <= '0;
      end else if (load_stage) begin
         stage_valid_q <= 1'b1;
         stage_instr_q <= pack_instr(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_func, in_imm);
      end else if (push) begin
         stage_valid_q <= 1'b0;
      end
   end

   // Write-address counter: advances by one word per push, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_addr_q <= RESET_ADDR;
      end else if (push) begin
         wr_addr_q <= push_addr + 32'd4;
      end else if (addr_ld) begin
         wr_addr_q <= ld_addr;
      end
   end

   assign push_entry.instr = stage_instr_q;
   assign push_entry.addr  = push_addr;

   instr_enc_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (out_ready),
      .full      (fifo_full),
      .valid     (out_valid),
      .head_data (head_entry)
   );

   assign out_instr = head_entry.instr;
   assign out_addr  = head_entry.addr;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, back-pressure,
// address load/wrap, mid-stream reset, immediate-range behaviour, then a
// randomized stream scored against an arithmetic reference model.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [9:0]  in_func;
   logic [31:0] in_imm;
   logic        addr_ld;
   logic [31:0] addr_ld_val;
   logic        out_valid, out_ready;
   logic [31:0] out_instr, out_addr;
   logic        err;

   always #5 clk = ~clk;

   instr_encoder #(
      .FIFO_DEPTH (DEPTH),
      .RESET_ADDR (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_fmt      (in_fmt),
      .in_opcode   (in_opcode),
      .in_rd       (in_rd),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_func     (in_func),
      .in_imm      (in_imm),
      .addr_ld     (addr_ld),
      .addr_ld_val (addr_ld_val),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_addr    (out_addr),
      .err         (err)
   );

   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [9:0]  func;
      logic [31:0] imm;
   } req_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_addr;
   logic        model_err;
   bit          use_override;
   logic [31:0] override_instr;
   int          total  = 0;
   int          passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Reference encoding built from bit-field arithmetic on the immediate.
   function automatic logic [31:0] ref_encode(input req_t r);
      int unsigned u, op, rd, rs1, rs2, f3, f7, res;
      u   = r.imm;
      op  = r.op;
      rd  = r.rd;
      rs1 = r.rs1;
      rs2 = r.rs2;
      f3  = r.func % 8;
      f7  = r.func / 8;
      if (r.fmt == FORMAT_U)
         res = (u / 4096) * 4096 + rd * 128 + op;
      else if (r.fmt == FORMAT_I)
         res = (u % 4096) * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + op;
      else if (r.fmt == FORMAT_S)
         res = ((u / 32) % 128) * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096
               + (u % 32) * 128 + op;
      else if (r.fmt == FORMAT_B)
         res = ((u / 4096) % 2) * 32'h8000_0000 + ((u / 32) % 64) * 33554432 + rs2 * 1048576
               + rs1 * 32768 + f3 * 4096 + ((u / 2) % 16) * 256 + ((u / 2048) % 2) * 128 + op;
      else if (r.fmt == FORMAT_J)
         res = ((u / 1048576) % 2) * 32'h8000_0000 + ((u / 2) % 1024) * 2097152
               + ((u / 2048) % 2) * 1048576 + ((u / 4096) % 256) * 4096 + rd * 128 + op;
      else
         res = f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + op;
      return res;
   endfunction

   // Reference range rule: does the immediate fit its format exactly?
   function automatic bit ref_bad(input req_t r);
      int s;
      s = $signed(r.imm);
      if (r.fmt == FORMAT_I || r.fmt == FORMAT_S) return (s < -2048 || s > 2047);
      if (r.fmt == FORMAT_B) return (s < -4096 || s > 4095 || (s % 2) != 0);
      if (r.fmt == FORMAT_J) return (s < -1048576 || s > 1048575 || (s % 2) != 0);
      if (r.fmt == FORMAT_U) return ((r.imm % 4096) != 0);
      return 1'b0;
   endfunction

   // Random request whose immediate is legal for its format.
   function automatic req_t rand_req();
      req_t r;
      r.fmt  = 3'($urandom_range(0, 7));
      r.op   = 7'($urandom);
      r.rd   = 5'($urandom);
      r.rs1  = 5'($urandom);
      r.rs2  = 5'($urandom);
      r.func = 10'($urandom);
      if (r.fmt == FORMAT_I || r.fmt == FORMAT_S)
         r.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      else if (r.fmt == FORMAT_B)
         r.imm = 32'(int'($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
      else if (r.fmt == FORMAT_J)
         r.imm = 32'(int'($urandom_range(0, 2097151)) - 1048576) & 32'hFFFF_FFFE;
      else if (r.fmt == FORMAT_U)
         r.imm = $urandom & 32'hFFFF_F000;
      else
         r.imm = $urandom;
      return r;
   endfunction

   // One clock cycle: drive, check against the model just before the edge,
   // update the model with the transfers that edge will perform.
   task automatic drive_cycle(input req_t r, input bit iv, input bit ordy, output bit acc);
      exp_t e;
      bit   bad;
      in_valid    = iv;
      in_fmt      = r.fmt;
      in_opcode   = r.op;
      in_rd       = r.rd;
      in_rs1      = r.rs1;
      in_rs2      = r.rs2;
      in_func     = r.func;
      in_imm      = r.imm;
      out_ready   = ordy;
      addr_ld     = 1'b0;
      addr_ld_val = 32'h0;
      @(negedge clk);
      check("in_ready", in_ready, (sb.size() < DEPTH + 1));
      check("err", err, model_err);
      if (sb.size() == 0) check("out_valid_idle", out_valid, 1'b0);
      if (out_valid && out_ready && sb.size() > 0) begin
         e = sb.pop_front();
         check("out_instr", out_instr, e.instr);
         check("out_addr", out_addr, e.addr);
      end
      acc = iv && in_ready;
      if (acc) begin
`ifdef INSTR_ENC_IMM_CHECK_EN
         bad = ref_bad(r);
`else
         bad = 1'b0;
`endif
         if (bad) begin
            model_err = 1'b1;
         end else begin
            e.instr = use_override ? override_instr : ref_encode(r);
            e.addr  = model_addr;
            sb.push_back(e);
            model_addr = model_addr + 32'd4;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      req_t idle;
      bit   acc;
      idle = '0;
      for (int i = 0; i < budget && sb.size() > 0; i++) drive_cycle(idle, 1'b0, 1'b1, acc);
      check("drain_done", sb.size(), 0);
   endtask

   // Send one request on an idle pipeline, expecting a fixed word.
   task automatic send_known(input req_t r, input logic [31:0] word);
      bit acc;
      use_override   = 1'b1;
      override_instr = word;
      drive_cycle(r, 1'b1, 1'b1, acc);
      use_override   = 1'b0;
      check("known_accept", acc, 1'b1);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      addr_ld   = 1'b1;
      addr_ld_val = 32'h0000_1230;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      rst     = 1'b0;
      addr_ld = 1'b0;
      sb.delete();
      model_addr = 32'h0;
      model_err  = 1'b0;
   endtask

   req_t r;
   req_t burst [6];
   bit   acc;
   int   n_acc;

   initial begin
      use_override = 1'b0;
      override_instr = '0;
      model_addr = 32'h0;
      model_err  = 1'b0;
      rst = 1'b1;
      in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_func = '0; in_imm = '0; addr_ld = 1'b0; addr_ld_val = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_in_ready", in_ready, 1'b1);
      check("reset_out_instr", out_instr, 32'h0);
      check("reset_out_addr", out_addr, 32'h0);
      check("reset_err", err, 1'b0);
      @(posedge clk);
      #1;

      // Directed encodings: addi, lui, sw, beq -4.
      r = '{fmt: FORMAT_I, op: 7'h13, rd: 5'd1, rs1: 5'd2, rs2: 5'd0, func: 10'd0, imm: 32'd5};
      send_known(r, 32'h0051_0093);
      r = '{fmt: FORMAT_U, op: 7'h37, rd: 5'd5, rs1: 5'd0, rs2: 5'd0, func: 10'd0, imm: 32'h1234_5000};
      send_known(r, 32'h1234_52B7);
      r = '{fmt: FORMAT_S, op: 7'h23, rd: 5'd0, rs1: 5'd2, rs2: 5'd3, func: 10'd2, imm: 32'd8};
      send_known(r, 32'h0031_2423);
      r = '{fmt: FORMAT_B, op: 7'h63, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, func: 10'd0, imm: 32'hFFFF_FFFC};
      send_known(r, 32'hFE00_0EE3);
      drain(20);

      // Back-pressure: six requests against a stalled sink.
      do_reset();
      for (int i = 0; i < 6; i++) burst[i] = rand_req();
      n_acc = 0;
      for (int c = 0; c < 10; c++) begin
         drive_cycle(burst[n_acc], 1'b1, 1'b0, acc);
         if (acc) n_acc++;
      end
      check("stall_accepted", n_acc, 5);
      for (int c = 0; c < 20 && n_acc < 6; c++) begin
         drive_cycle(burst[n_acc], 1'b1, 1'b1, acc);
         if (acc) n_acc++;
      end
      check("release_accepted", n_acc, 6);
      drain(30);

      // Address load with unaligned value, wrap across zero.
      in_valid = 1'b0; out_ready = 1'b1;
      addr_ld = 1'b1; addr_ld_val = 32'hFFFF_FFFE;
      @(posedge clk);
      #1;
      addr_ld = 1'b0;
      model_addr = 32'hFFFF_FFFC;
      for (int i = 0; i < 2; i++) begin
         drive_cycle(rand_req(), 1'b1, 1'b1, acc);
         check("wrap_accept", acc, 1'b1);
      end
      drain(20);

      // Reset mid-stream discards everything and restarts the counter.
      for (int i = 0; i < 3; i++) drive_cycle(rand_req(), 1'b1, 1'b0, acc);
      do_reset();
      drive_cycle(rand_req(), 1'b1, 1'b1, acc);
      drain(20);

      // Out-of-range I immediate (2048).
      r = '{fmt: FORMAT_I, op: 7'h13, rd: 5'd7, rs1: 5'd8, rs2: 5'd0, func: 10'd0, imm: 32'd2048};
      drive_cycle(r, 1'b1, 1'b1, acc);
      for (int i = 0; i < 4; i++) drive_cycle(r, 1'b0, 1'b1, acc);
      drain(20);
      drive_cycle(rand_req(), 1'b1, 1'b1, acc);
      drain(20);

      // Randomized stream with random back-pressure.
      for (int c = 0; c < 400; c++) begin
         drive_cycle(rand_req(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), acc);
      end
      drain(60);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output buffer entries; power of two, minimum 2.
REQ-002 Parameter RESET_ADDR, default 32'h0000_0000, initial write address.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 in_valid  in  1  encode request valid.
REQ-006 in_ready  out  1  encoder can accept a request this cycle.
REQ-007 in_fmt  in  3  immediate format code (FORMAT_U/I/S/B/J/NO_IMM, shared package).
REQ-008 in_opcode  in  7  opcode field.
REQ-009 in_rd, in_rs1, in_rs2  in  5 each  register indices.
REQ-010 in_func  in  10  {funct7, funct3}, same packing as the decoder func output.
REQ-011 in_imm  in  32  unpacked, sign-extended immediate value.
REQ-012 addr_ld  in  1  load write address from addr_ld_val.
REQ-013 addr_ld_val  in  32  new write address; bits [1:0] ignored and forced to 0.
REQ-014 out_valid  out  1  buffered instruction available.
REQ-015 out_ready  in  1  instruction-memory sink accepts the word.
REQ-016 out_instr  out  32  encoded instruction word.
REQ-017 out_addr  out  32  instruction-memory byte address for out_instr.
REQ-018 err  out  1  sticky immediate-range error.

Function
REQ-019 Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-020 Encoding: one register stage, then FIFO; an accepted request appears at the FIFO head no earlier than 2 cycles after acceptance.
REQ-021 Field packing: U {imm[31:12],rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; NO_IMM {f7,rs2,rs1,f3,rd,op}.
REQ-022 Unknown in_fmt values encode as NO_IMM.
REQ-023 in_ready = !(stage register full && next cycle has no room), i.e. deasserted only when the stage register and the FIFO are both full; no combinational path from out_ready to in_ready.
REQ-024 FIFO occupancy FSM: EMPTY -> PARTIAL on push; PARTIAL -> FULL at FIFO_DEPTH; FULL -> PARTIAL on pop; PARTIAL -> EMPTY on last pop; simultaneous push and pop keeps state and count.
REQ-025 out_valid = state != EMPTY; out_instr/out_addr held stable while out_valid && !out_ready.
REQ-026 Write-address counter assigned at FIFO push, then increments by 4; wraps 32'hFFFF_FFFC -> 0.
REQ-027 addr_ld affects only instructions pushed after the edge on which it is sampled; addr_ld and push on the same edge: pushed entry takes addr_ld_val, counter becomes addr_ld_val+4.

Reset
REQ-028 On rst: FIFO EMPTY, stage register empty, out_valid=0, in_ready=1, counter=RESET_ADDR, err=0, out_instr=0, out_addr=0; in-flight and buffered requests discarded.
REQ-029 rst dominates addr_ld and all handshakes on the same edge.

Configuration
REQ-030 Macro INSTR_ENC_IMM_CHECK_EN defined: range violations (I/S not sign-extended from bit 11; B not from bit 12 or imm[0]=1; J not from bit 20 or imm[0]=1; U imm[11:0]!=0) set err and drop the request (accepted, never pushed, counter unchanged).
REQ-031 Macro undefined: immediates silently truncated per REQ-021, nothing dropped, err tied 0.

Structure
REQ-032 Shared package/header holds format codes, opcode constants, field widths; shared with the decoder.
REQ-033 One sub-module instr_enc_fifo (parameterised FIFO_DEPTH x 64 bits: instr+addr) is natural; packing logic stays in instr_encoder.

Verification
REQ-034 I, addi x1,x2,5 (op 0x13, f3 0, imm 5), out_ready=1 -> out_instr 32'h00510093 at out_addr 0.
REQ-035 U, lui x5 (op 0x37, imm 32'h12345000) -> 32'h123452B7; S, sw x3,8(x2) (op 0x23, f3 2) -> 32'h00312423; addresses 0, 4.
REQ-036 B, beq x0,x0 imm -4 (op 0x63) -> 32'hFE000EE3.
REQ-037 out_ready=0, stream 6 requests with FIFO_DEPTH 4 -> in_ready falls after 5 accepted; release -> all 5 in order, addresses 0..16, then 6th.
REQ-038 addr_ld_val 32'hFFFF_FFFC, push 2 -> addresses FFFF_FFFC then 0; rst mid-stream -> out_valid 0 next cycle, counter 0.
REQ-039 With INSTR_ENC_IMM_CHECK_EN, I-format imm 2048 -> err=1, no output, counter unchanged; without it -> word emitted with imm[11:0]=12'h800, err 0.
